// File: rtl/chi_sq_pkg.sv
// Shared types and width helpers for the chi-squared goodness-of-fit engine.
package chi_sq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        DIFF   = 3'd2,
        SQUARE = 3'd3,
        DIVIDE = 3'd4,
        ACCUM  = 3'd5,
        DONE   = 3'd6
    } state_t;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, done pulses NUM_W+1
// cycles after start. The remainder is kept only as working state.
module seq_divider #(
    parameter int NUM_W = 32,
    parameter int DEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic [NUM_W-1:0] quo,
    output logic             done
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] quo_r;
    logic [DEN_W-1:0] rem_r;
    logic [DEN_W-1:0] den_r;
    logic [CNT_W-1:0] cnt_r;
    logic             run_r;
    logic             done_r;
    logic [DEN_W:0]   rem_shift_s;
    logic [DEN_W:0]   rem_sub_s;
    logic             fits_s;

    // Trial subtraction; a clear borrow bit means the divisor fits.
    always_comb begin
        rem_shift_s = {rem_r, quo_r[NUM_W-1]};
        rem_sub_s   = rem_shift_s - {1'b0, den_r};
        fits_s      = ~rem_sub_s[DEN_W];
    end

    // Load on start, then shift one dividend bit per cycle into the quotient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_r  <= {NUM_W{1'b0}};
            rem_r  <= {DEN_W{1'b0}};
            den_r  <= {DEN_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            run_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                quo_r <= num;
                rem_r <= {DEN_W{1'b0}};
                den_r <= den;
                cnt_r <= CNT_W'(NUM_W);
                run_r <= 1'b1;
            end else if (run_r) begin
                quo_r <= {quo_r[NUM_W-2:0], fits_s};
                rem_r <= fits_s ? rem_sub_s[DEN_W-1:0] : rem_shift_s[DEN_W-1:0];
                cnt_r <= cnt_r - CNT_W'(32'd1);
                if (cnt_r == CNT_W'(32'd1)) begin
                    run_r  <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign quo  = quo_r;
    assign done = done_r;

endmodule

// File: rtl/chi_squared_gof.sv
// Chi-squared goodness-of-fit engine: accumulates sum((O-E)^2/E) over NUM_BINS
// streamed bins with saturation, then compares against a run-time critical value.
module chi_squared_gof
    import chi_sq_pkg::*;
#(
    parameter int NUM_BINS = 6,
    parameter int OBS_W    = 16,
    parameter int EXP_W    = 16,
    parameter int ACC_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] crit_val,
    input  logic             bin_valid,
    output logic             bin_ready,
    input  logic [OBS_W-1:0] obs_in,
    input  logic [EXP_W-1:0] exp_in,
    output logic             busy,
    output logic [ACC_W-1:0] chi_out,
    output logic             result_valid,
    output logic             reject,
    output logic             sat,
    output logic             zero_err
);

    localparam int W     = max_w(OBS_W, EXP_W);
    localparam int NUM_W = 2 * W;
    localparam int CNT_W = (NUM_BINS > 2) ? $clog2(NUM_BINS) : 1;
    localparam int SUM_W = max_w(NUM_W, ACC_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(NUM_BINS - 1);
    localparam logic [SUM_W-1:0] ACC_MAX  = SUM_W'({ACC_W{1'b1}});

    state_t           state_r;
    logic [CNT_W-1:0] bin_cnt_r;
    logic [ACC_W-1:0] crit_r;
    logic [W-1:0]     obs_r;
    logic [W-1:0]     exp_r;
    logic [W-1:0]     d_r;
    logic [NUM_W-1:0] q_r;
    logic [ACC_W-1:0] chi_r;
    logic             reject_r;
    logic             sat_r;
    logic             zero_err_r;
    logic             result_valid_r;
    logic             busy_r;
    logic             bin_ready_r;

    logic [NUM_W-1:0] sq_s;
    logic             div_start_s;
    logic [NUM_W-1:0] div_quo_s;
    logic             div_done_s;
    logic [SUM_W-1:0] sum_s;
    logic             over_s;
    logic [ACC_W-1:0] acc_next_s;

    // The square feeds the divider directly so DIVIDE is exactly NUM_W+1 cycles.
    always_comb begin
        sq_s        = {{W{1'b0}}, d_r} * {{W{1'b0}}, d_r};
        div_start_s = (state_r == SQUARE);
        sum_s       = SUM_W'(chi_r) + SUM_W'(q_r);
        over_s      = (sum_s > ACC_MAX);
        acc_next_s  = over_s ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
    end

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start_s),
        .num   (sq_s),
        .den   (exp_r),
        .quo   (div_quo_s),
        .done  (div_done_s)
    );

    // Test sequencing FSM with registered handshake, status and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            bin_cnt_r      <= {CNT_W{1'b0}};
            crit_r         <= {ACC_W{1'b0}};
            obs_r          <= {W{1'b0}};
            exp_r          <= {W{1'b0}};
            d_r            <= {W{1'b0}};
            q_r            <= {NUM_W{1'b0}};
            chi_r          <= {ACC_W{1'b0}};
            reject_r       <= 1'b0;
            sat_r          <= 1'b0;
            zero_err_r     <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            bin_ready_r    <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        chi_r       <= {ACC_W{1'b0}};
                        reject_r    <= 1'b0;
                        sat_r       <= 1'b0;
                        zero_err_r  <= 1'b0;
                        crit_r      <= crit_val;
                        bin_cnt_r   <= {CNT_W{1'b0}};
                        busy_r      <= 1'b1;
                        bin_ready_r <= 1'b1;
                        state_r     <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (bin_valid && bin_ready_r) begin
                        obs_r       <= W'(obs_in);
                        exp_r       <= W'(exp_in);
                        bin_ready_r <= 1'b0;
                        state_r     <= DIFF;
                    end
                end
                DIFF: begin
                    d_r     <= (obs_r >= exp_r) ? (obs_r - exp_r) : (exp_r - obs_r);
                    state_r <= SQUARE;
                end
                SQUARE: begin
                    state_r <= DIVIDE;
                end
                DIVIDE: begin
                    // E==0 still waits out the divider so every bin costs the same.
                    if (div_done_s) begin
                        if (exp_r == {W{1'b0}}) begin
                            q_r        <= {NUM_W{1'b0}};
                            zero_err_r <= 1'b1;
                        end else begin
                            q_r <= div_quo_s;
                        end
                        state_r <= ACCUM;
                    end
                end
                ACCUM: begin
                    chi_r <= acc_next_s;
                    if (over_s) begin
                        sat_r <= 1'b1;
                    end
                    if (bin_cnt_r == LAST_BIN) begin
                        result_valid_r <= 1'b1;
                        reject_r       <= (acc_next_s > crit_r);
                        state_r        <= DONE;
                    end else begin
                        bin_cnt_r   <= bin_cnt_r + CNT_W'(32'd1);
                        bin_ready_r <= 1'b1;
                        state_r     <= ACCEPT;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r      <= 1'b0;
                    bin_ready_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bin_ready    = bin_ready_r;
    assign busy         = busy_r;
    assign chi_out      = chi_r;
    assign result_valid = result_valid_r;
    assign reject       = reject_r;
    assign sat          = sat_r;
    assign zero_err     = zero_err_r;

endmodule

// File: tb/tb_chi_squared_gof.sv
// Directed bench for chi_squared_gof: a default instance plus a 16-bit
// accumulator instance driven by the same stimulus.
module tb_chi_squared_gof;

    localparam int NB       = 6;
    localparam int NUM_W    = 32;
    localparam int GAP      = NUM_W + 4;
    localparam int EXP_CYC  = NB * (NUM_W + 5) + 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] crit_val;
    logic        bin_valid;
    logic [15:0] obs_in;
    logic [15:0] exp_in;

    logic        bin_ready, busy, result_valid, reject, sat, zero_err;
    logic [31:0] chi_out;
    logic        s_bin_ready, s_busy, s_result_valid, s_reject, s_sat, s_zero_err;
    logic [15:0] s_chi_out;

    logic [15:0] obs_tab [NB];
    logic [15:0] exp_tab [NB];
    int r_cycles, r_rv, r_hs, r_gaps, r_gap_bad, r_busy_bad;
    logic r_busy_after;
    int n_checks = 0;
    int n_fail   = 0;

    chi_squared_gof dut (
        .clk(clk), .rst(rst), .start(start), .crit_val(crit_val),
        .bin_valid(bin_valid), .bin_ready(bin_ready), .obs_in(obs_in), .exp_in(exp_in),
        .busy(busy), .chi_out(chi_out), .result_valid(result_valid),
        .reject(reject), .sat(sat), .zero_err(zero_err)
    );

    chi_squared_gof #(.ACC_W(16)) dut_s (
        .clk(clk), .rst(rst), .start(start), .crit_val(crit_val[15:0]),
        .bin_valid(bin_valid), .bin_ready(s_bin_ready), .obs_in(obs_in), .exp_in(exp_in),
        .busy(s_busy), .chi_out(s_chi_out), .result_valid(s_result_valid),
        .reject(s_reject), .sat(s_sat), .zero_err(s_zero_err)
    );

    always #5 clk = ~clk;

    // Drives one test from start through result (or through abort_hs handshakes
    // plus ten cycles) and records timing observations.
    task automatic run_test(input logic [31:0] crit, input bit rand_valid,
                            input bit mid_start, input int abort_hs);
        int  i = 0;
        int  low_run = 0;
        int  ab_cnt = 0;
        bit  prev_ready = 1'b0;
        bit  done_seen = 1'b0;
        r_cycles = 0; r_rv = 0; r_hs = 0; r_gaps = 0; r_gap_bad = 0; r_busy_bad = 0;
        @(negedge clk);
        crit_val = crit;
        start    = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 2000 && !done_seen; c++) begin
            if (abort_hs > 0 && r_hs >= abort_hs) begin
                ab_cnt++;
                if (ab_cnt > 10) break;
            end
            if (result_valid === 1'b1) begin
                done_seen = 1'b1;
                r_cycles  = c;
            end
            if (busy !== 1'b1) r_busy_bad++;
            if (bin_ready === 1'b1) begin
                if (!prev_ready && i > 0) begin
                    r_gaps++;
                    if (low_run != GAP) r_gap_bad++;
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_ready = (bin_ready === 1'b1);
            start = (mid_start && c == 50);
            if (i < NB) begin
                obs_in    = obs_tab[i];
                exp_in    = exp_tab[i];
                bin_valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
            end else begin
                bin_valid = 1'b0;
            end
            if (bin_valid && bin_ready === 1'b1) begin
                r_hs++;
                i++;
            end
            @(negedge clk);
        end
        start     = 1'b0;
        bin_valid = 1'b0;
        if (abort_hs == 0) begin
            n_checks++;
            if (!done_seen) begin
                n_fail++;
                $display("FAIL timeout: result_valid not seen within 2000 cycles");
            end
            r_rv = done_seen ? 1 : 0;
            r_busy_after = busy;
            for (int k = 0; k < 5; k++) begin
                if (result_valid === 1'b1) r_rv++;
                if (bin_valid && bin_ready === 1'b1) r_hs++;
                @(negedge clk);
            end
        end
    endtask

    task automatic load_basic();
        obs_tab = '{16'd80, 16'd80, 16'd120, 16'd120, 16'd140, 16'd60};
        exp_tab = '{16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100};
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bin_ready, busy, chi_out, result_valid, reject, sat, zero_err} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0",
                     {bin_ready, busy, chi_out, result_valid, reject, sat, zero_err});
        end
        n_checks++;
        if ({s_bin_ready, s_busy, s_chi_out, s_result_valid, s_reject, s_sat, s_zero_err} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_state_acc16: got %h expected 0",
                     {s_bin_ready, s_busy, s_chi_out, s_result_valid, s_reject, s_sat, s_zero_err});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        load_basic();
        run_test(32'd11, 1'b0, 1'b0, 0);
        n_checks++; if (chi_out !== 32'd48) begin n_fail++; $display("FAIL basic_chi: got %0d expected 48", chi_out); end
        n_checks++; if (reject !== 1'b1) begin n_fail++; $display("FAIL basic_reject: got %b expected 1", reject); end
        n_checks++; if ({sat, zero_err} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b expected 00", {sat, zero_err}); end
        n_checks++; if (r_rv != 1) begin n_fail++; $display("FAIL basic_rv_pulses: got %0d expected 1", r_rv); end
        n_checks++; if (r_cycles != EXP_CYC) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", r_cycles, EXP_CYC); end
        n_checks++; if (r_busy_bad != 0 || r_busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy: low cycles %0d, after %b expected 0,0", r_busy_bad, r_busy_after); end
        n_checks++; if (r_gaps != NB - 1 || r_gap_bad != 0) begin n_fail++; $display("FAIL basic_ready_gap: gaps %0d bad %0d expected %0d,0", r_gaps, r_gap_bad, NB - 1); end
    endtask

    task automatic test_truncation();
        obs_tab = '{16'd10, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3};
        exp_tab = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3};
        run_test(32'd16, 1'b0, 1'b0, 0);
        n_checks++; if (chi_out !== 32'd16) begin n_fail++; $display("FAIL trunc_chi: got %0d expected 16", chi_out); end
        n_checks++; if (reject !== 1'b0) begin n_fail++; $display("FAIL trunc_reject_equal: got %b expected 0", reject); end
    endtask

    task automatic test_zero_exp();
        obs_tab = '{16'd50, 16'd50, 16'd500, 16'd50, 16'd50, 16'd50};
        exp_tab = '{16'd50, 16'd50, 16'd0, 16'd50, 16'd50, 16'd50};
        run_test(32'd0, 1'b0, 1'b0, 0);
        n_checks++; if (chi_out !== 32'd0) begin n_fail++; $display("FAIL zero_chi: got %0d expected 0", chi_out); end
        n_checks++; if (zero_err !== 1'b1 || sat !== 1'b0) begin n_fail++; $display("FAIL zero_flags: got zero_err=%b sat=%b expected 1,0", zero_err, sat); end
        n_checks++; if (r_cycles != EXP_CYC) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", r_cycles, EXP_CYC); end
    endtask

    task automatic test_saturation();
        obs_tab = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
        exp_tab = '{16'd60000, 16'd60000, 16'd1, 16'd1, 16'd1, 16'd1};
        run_test(32'd0, 1'b0, 1'b0, 0);
        n_checks++; if (s_chi_out !== 16'd65535) begin n_fail++; $display("FAIL sat16_chi: got %0d expected 65535", s_chi_out); end
        n_checks++; if (s_sat !== 1'b1 || s_reject !== 1'b1) begin n_fail++; $display("FAIL sat16_flags: got sat=%b reject=%b expected 1,1", s_sat, s_reject); end
        n_checks++; if (chi_out !== 32'd120000 || sat !== 1'b0) begin n_fail++; $display("FAIL sat32_nosat: got chi=%0d sat=%b expected 120000,0", chi_out, sat); end
    endtask

    task automatic test_backpressure();
        load_basic();
        run_test(32'd11, 1'b1, 1'b1, 0);
        n_checks++; if (r_hs != NB) begin n_fail++; $display("FAIL bp_handshakes: got %0d expected %0d", r_hs, NB); end
        n_checks++; if (r_gaps != NB - 1 || r_gap_bad != 0) begin n_fail++; $display("FAIL bp_ready_gap: gaps %0d bad %0d expected %0d,0", r_gaps, r_gap_bad, NB - 1); end
        n_checks++; if (chi_out !== 32'd48 || r_rv != 1) begin n_fail++; $display("FAIL bp_result: got chi=%0d pulses=%0d expected 48,1", chi_out, r_rv); end
    endtask

    task automatic test_reset_mid();
        int rv_cnt = 0;
        load_basic();
        run_test(32'd11, 1'b0, 1'b0, 4);
        n_checks++; if (chi_out !== 32'd12) begin n_fail++; $display("FAIL mid_partial_chi: got %0d expected 12", chi_out); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bin_ready, busy, chi_out, result_valid, reject, sat, zero_err} !== 38'd0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got %h expected 0",
                     {bin_ready, busy, chi_out, result_valid, reject, sat, zero_err});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (result_valid === 1'b1 || busy === 1'b1) rv_cnt++;
        end
        n_checks++; if (rv_cnt != 0) begin n_fail++; $display("FAIL mid_no_result: got %0d active cycles expected 0", rv_cnt); end
        run_test(32'd11, 1'b0, 1'b0, 0);
        n_checks++; if (chi_out !== 32'd48 || reject !== 1'b1) begin n_fail++; $display("FAIL mid_rerun: got chi=%0d reject=%b expected 48,1", chi_out, reject); end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; crit_val = 32'd0;
        bin_valid = 1'b0; obs_in = 16'd0; exp_in = 16'd0;
        test_reset();
        test_basic();
        test_truncation();
        test_zero_exp();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chi_squared_gof.md
# chi_squared_gof

Parametrised chi-squared goodness-of-fit engine for the statistics datapath. It accepts one (observed, expected) count pair per bin over a valid/ready stream, and accumulates the sum over all bins of (O−E)²/E. It then compares the statistic against a run-time critical value and reports accept/reject. It sits downstream of the histogram/bin counters and upstream of the result register block. It replaces the fixed 6-bin, hard-coded-expectation engine.

## Interface
Parameters:
- NUM_BINS, 6, bins per test (≥2); degrees of freedom = NUM_BINS−1
- OBS_W, 16, observed-count width
- EXP_W, 16, expected-count width
- ACC_W, 32, statistic/accumulator width
- Derived: W = max(OBS_W, EXP_W); NUM_W = 2·W (squared-difference width)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse, begins a test; honoured only in IDLE
- crit_val  in  ACC_W  critical value; sampled on accepted start
- bin_valid  in  1  obs_in/exp_in valid
- bin_ready  out  1  engine can take a bin
- obs_in  in  OBS_W  observed count O
- exp_in  in  EXP_W  expected count E
- busy  out  1  high from accepted start through DONE
- chi_out  out  ACC_W  statistic, integer-truncated per term
- result_valid  out  1  one-cycle pulse, result complete
- reject  out  1  chi_out > crit_val, valid with result_valid, held after
- sat  out  1  accumulator saturated this test
- zero_err  out  1  a bin had E == 0 this test

## Operation
- Reset: all outputs 0, state IDLE, bin counter 0, divider idle.
- IDLE: start → clear chi_out, reject, sat, zero_err; latch crit_val; bin_cnt=0; → ACCEPT. start in any other state is ignored.
- ACCEPT: bin_ready=1. On bin_valid&bin_ready, capture O and E (zero-extended to W) → DIFF. The source holds data until the handshake.
- DIFF: d = |O−E| (W bits, no overflow) → SQUARE.
- SQUARE: sq = d·d (NUM_W bits, exact) → DIVIDE.
- DIVIDE: iterative restoring divider, q = floor(sq/E). If E==0: no division, term = 0, set zero_err.
- ACCUM: acc = acc + zext(q). If the true sum exceeds 2^ACC_W−1, clamp to all-ones and set sat. A q wider than ACC_W with non-zero upper bits also saturates. If bin_cnt==NUM_BINS−1 → DONE; else bin_cnt++ → ACCEPT.
- DONE: result_valid=1 for one cycle, reject = (chi_out > crit_val) → IDLE. chi_out and flags hold until the next accepted start.
- Reset mid-test: everything returns to reset values immediately; no partial result is reported.

## Timing
- bin_ready is high only in ACCEPT. It drops the cycle after the handshake.
- Per-bin latency, handshake to next bin_ready high: NUM_W+4 cycles. That is DIFF 1 + SQUARE 1 + DIVIDE NUM_W+1 + ACCUM 1. Defaults give 36.
- E==0 bins take the same cycle count; the divider is bypassed but DIVIDE still spends NUM_W+1 cycles.
- Last ACCUM → result_valid in the next cycle (DONE). Next start is accepted in IDLE, one cycle after DONE.
- chi_out updates in the cycle after each ACCUM, so the partial sum is visible. It is final when result_valid is high.
- busy is 1 from the cycle after the accepted start through DONE inclusive.

## Structure
- Package chi_sq_pkg: state enum typedef (IDLE, ACCEPT, DIFF, SQUARE, DIVIDE, ACCUM, DONE); width helper function for max(OBS_W, EXP_W).
- Sub-module seq_divider #(NUM_W, DEN_W): start/done handshake, one quotient bit per cycle, done pulse NUM_W+1 cycles after start; remainder discarded.
- Top holds the FSM, bin counter, saturating accumulator and comparator.

## Test plan
- Default params, crit_val=11; O=[80,80,120,120,140,60], E=100 each → terms 4,4,4,4,16,16; chi_out=48, reject=1, sat=0, zero_err=0, one result_valid pulse.
- Truncation: O=[10,3,3,3,3,3], E=3 each → first term 49/3=16, rest 0; chi_out=16. With crit_val=16 → reject=0.
- Zero expectation: bin 2 with E=0, O=500; other bins O=E=50 → chi_out=0, zero_err=1, same total cycle count as a normal test.
- Saturation: ACC_W=16; O=0, E=60000 on bins 0 and 1 → 60000+60000 clamps to chi_out=65535, sat=1.
- Backpressure/handshake: bin_valid toggled randomly, start re-pulsed mid-test → ignored; exactly NUM_BINS handshakes; bin_ready spacing is 36 cycles.
- Reset mid-DIVIDE on bin 3 → all outputs 0, no result_valid. A fresh start then reproduces the first scenario's result.
